// File: rtl/race_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : race_sequencer_if
// Description : Start request, player positions and game-status bundle
//               for the race sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface race_sequencer_if;
    logic       start_key;
    logic [9:0] p1_x;
    logic [9:0] p1_y;
    logic [9:0] p2_x;
    logic [9:0] p2_y;
    logic [2:0] state;
    logic [3:0] count_val;
    logic       round_rst;
    logic [2:0] p1_lap;
    logic [2:0] p2_lap;
    logic [1:0] winner;
    logic [9:0] race_secs;

    modport master (
        output start_key, p1_x, p1_y, p2_x, p2_y,
        input  state, count_val, round_rst, p1_lap, p2_lap, winner, race_secs
    );

    modport slave (
        input  start_key, p1_x, p1_y, p2_x, p2_y,
        output state, count_val, round_rst, p1_lap, p2_lap, winner, race_secs
    );
endinterface
`default_nettype wire

// File: rtl/race_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : race_sequencer
// Description : Two-player race game sequencer: start edge, countdown,
//               lap/checkpoint tracking, winner decision and race timer.
// Revision    : 1.0 - initial release
// ============================================================================
module race_sequencer #(
    parameter int TICK_CYCLES = 100_000_000,
    parameter int COUNT_SECS  = 3,
    parameter int LAPS        = 3,
    parameter int FL_X0       = 0,
    parameter int FL_X1       = 40,
    parameter int FL_Y0       = 115,
    parameter int FL_Y1       = 118,
    parameter int CP_X0       = 280,
    parameter int CP_X1       = 319,
    parameter int CP_Y0       = 115,
    parameter int CP_Y1       = 118
) (
    input  wire logic      clk,
    input  wire logic      rst,
    race_sequencer_if.slave bus
);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_count  = 3'd2;
    localparam logic [2:0] c_st_race   = 3'd4;
    localparam logic [2:0] c_st_finish = 3'd5;

    localparam int                    c_tick_w     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [c_tick_w-1:0]   c_tick_max   = c_tick_w'(TICK_CYCLES - 1);
    localparam logic [3:0]            c_count_init = 4'(COUNT_SECS);
    localparam logic [2:0]            c_laps       = 3'(LAPS);
    localparam logic [9:0]            c_secs_max   = 10'd999;

    localparam logic [9:0] c_fl_x0 = 10'(FL_X0);
    localparam logic [9:0] c_fl_x1 = 10'(FL_X1);
    localparam logic [9:0] c_fl_y0 = 10'(FL_Y0);
    localparam logic [9:0] c_fl_y1 = 10'(FL_Y1);
    localparam logic [9:0] c_cp_x0 = 10'(CP_X0);
    localparam logic [9:0] c_cp_x1 = 10'(CP_X1);
    localparam logic [9:0] c_cp_y0 = 10'(CP_Y0);
    localparam logic [9:0] c_cp_y1 = 10'(CP_Y1);

    logic [2:0]          r_state;
    logic [3:0]          r_count_val;
    logic                r_round_rst;
    logic [2:0]          r_p1_lap;
    logic [2:0]          r_p2_lap;
    logic [1:0]          r_winner;
    logic [9:0]          r_race_secs;
    logic [c_tick_w-1:0] r_tick_cnt;
    logic                r_p1_armed;
    logic                r_p2_armed;
    logic                r_start_q;

    function automatic logic f_in_box(input logic [9:0] x, y, x0, x1, y0, y1);
        return (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
    endfunction

    logic       w_start_pulse;
    logic       w_tick;
    logic       w_p1_in_fl;
    logic       w_p1_in_cp;
    logic       w_p2_in_fl;
    logic       w_p2_in_cp;
    logic       w_p1_hit;
    logic       w_p2_hit;
    logic [2:0] w_p1_lap_nxt;
    logic [2:0] w_p2_lap_nxt;
    logic       w_p1_done;
    logic       w_p2_done;

    assign w_start_pulse = bus.start_key & ~r_start_q;
    assign w_tick        = (r_tick_cnt == c_tick_max);

    assign w_p1_in_fl = f_in_box(bus.p1_x, bus.p1_y, c_fl_x0, c_fl_x1, c_fl_y0, c_fl_y1);
    assign w_p1_in_cp = f_in_box(bus.p1_x, bus.p1_y, c_cp_x0, c_cp_x1, c_cp_y0, c_cp_y1);
    assign w_p2_in_fl = f_in_box(bus.p2_x, bus.p2_y, c_fl_x0, c_fl_x1, c_fl_y0, c_fl_y1);
    assign w_p2_in_cp = f_in_box(bus.p2_x, bus.p2_y, c_cp_x0, c_cp_x1, c_cp_y0, c_cp_y1);

    // A lap only counts when the checkpoint was visited first; clearing
    // armed on the count makes lingering in the finish box count once.
    assign w_p1_hit     = w_p1_in_fl & r_p1_armed;
    assign w_p2_hit     = w_p2_in_fl & r_p2_armed;
    assign w_p1_lap_nxt = r_p1_lap + {2'b00, w_p1_hit};
    assign w_p2_lap_nxt = r_p2_lap + {2'b00, w_p2_hit};
    assign w_p1_done    = w_p1_hit && (w_p1_lap_nxt == c_laps);
    assign w_p2_done    = w_p2_hit && (w_p2_lap_nxt == c_laps);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_count_val <= 4'd0;
            r_round_rst <= 1'b0;
            r_p1_lap    <= 3'd0;
            r_p2_lap    <= 3'd0;
            r_winner    <= 2'd0;
            r_race_secs <= 10'd0;
            r_tick_cnt  <= '0;
            r_p1_armed  <= 1'b0;
            r_p2_armed  <= 1'b0;
            r_start_q   <= 1'b0;
        end else begin
            r_start_q   <= bus.start_key;
            r_round_rst <= 1'b0;

            if (w_tick) begin
                r_tick_cnt <= '0;
            end else begin
                r_tick_cnt <= r_tick_cnt + c_tick_w'(1);
            end

            case (r_state)
                c_st_idle: begin
                    if (w_start_pulse) begin
                        r_state     <= c_st_count;
                        r_count_val <= c_count_init;
                        r_round_rst <= 1'b1;
                        r_p1_lap    <= 3'd0;
                        r_p2_lap    <= 3'd0;
                        r_winner    <= 2'd0;
                        r_race_secs <= 10'd0;
                        r_p1_armed  <= 1'b0;
                        r_p2_armed  <= 1'b0;
                        r_tick_cnt  <= '0;
                    end
                end

                c_st_count: begin
                    if (w_tick) begin
                        if (r_count_val == 4'd1) begin
                            r_state     <= c_st_race;
                            r_count_val <= 4'd0;
                        end else begin
                            r_count_val <= r_count_val - 4'd1;
                        end
                    end
                end

                c_st_race: begin
                    if (w_tick && (r_race_secs != c_secs_max)) begin
                        r_race_secs <= r_race_secs + 10'd1;
                    end

                    if (w_p1_hit) begin
                        r_p1_lap   <= w_p1_lap_nxt;
                        r_p1_armed <= 1'b0;
                    end else if (w_p1_in_cp) begin
                        r_p1_armed <= 1'b1;
                    end

                    if (w_p2_hit) begin
                        r_p2_lap   <= w_p2_lap_nxt;
                        r_p2_armed <= 1'b0;
                    end else if (w_p2_in_cp) begin
                        r_p2_armed <= 1'b1;
                    end

                    // {p2,p1} completion bits map directly to 1=P1, 2=P2, 3=tie
                    if (w_p1_done || w_p2_done) begin
                        r_state  <= c_st_finish;
                        r_winner <= {w_p2_done, w_p1_done};
                    end
                end

                c_st_finish: begin
                    if (w_start_pulse) begin
                        r_state <= c_st_idle;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.state     = r_state;
    assign bus.count_val = r_count_val;
    assign bus.round_rst = r_round_rst;
    assign bus.p1_lap    = r_p1_lap;
    assign bus.p2_lap    = r_p2_lap;
    assign bus.winner    = r_winner;
    assign bus.race_secs = r_race_secs;

endmodule
`default_nettype wire

// File: tb/tb_race_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_race_sequencer
// Description : Directed self-checking bench for race_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_race_sequencer;

    logic clk = 1'b0;
    logic rst;
    logic rst2;

    always #5 clk = ~clk;

    race_sequencer_if bus ();
    race_sequencer_if bus2 ();

    race_sequencer #(
        .TICK_CYCLES (4),
        .COUNT_SECS  (3),
        .LAPS        (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // One-cycle tick so the race timer reaches saturation quickly
    race_sequencer #(
        .TICK_CYCLES (1),
        .COUNT_SECS  (1),
        .LAPS        (2)
    ) dut_sat (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pos(input logic [9:0] ax, ay, bx, by);
        bus.p1_x = ax;
        bus.p1_y = ay;
        bus.p2_x = bx;
        bus.p2_y = by;
    endtask

    task automatic test_reset;
        logic [25:0] got;
        rst = 1'b1;
        rst2 = 1'b1;
        bus.start_key = 1'b0;
        bus2.start_key = 1'b0;
        set_pos(10'd150, 10'd200, 10'd150, 10'd200);
        bus2.p1_x = 10'd150; bus2.p1_y = 10'd200;
        bus2.p2_x = 10'd150; bus2.p2_y = 10'd200;
        step(2);
        got = {bus.state, bus.count_val, bus.round_rst, bus.p1_lap, bus.p2_lap, bus.winner, bus.race_secs};
        n_checks++;
        if (got !== 26'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", got, 26'd0);
        end
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_countdown;
        bus.start_key = 1'b1;
        step(1);
        n_checks++;
        if ({bus.state, bus.count_val, bus.round_rst} !== {3'd2, 4'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL cd_enter: got %h expected %h", {bus.state, bus.count_val, bus.round_rst}, {3'd2, 4'd3, 1'b1});
        end
        step(3);
        n_checks++;
        if ({bus.state, bus.count_val, bus.round_rst} !== {3'd2, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL cd_hold3: got %h expected %h", {bus.state, bus.count_val, bus.round_rst}, {3'd2, 4'd3, 1'b0});
        end
        step(1);
        n_checks++;
        if ({bus.state, bus.count_val} !== {3'd2, 4'd2}) begin
            n_fail++;
            $display("FAIL cd_step2: got %h expected %h", {bus.state, bus.count_val}, {3'd2, 4'd2});
        end
        step(4);
        n_checks++;
        if ({bus.state, bus.count_val} !== {3'd2, 4'd1}) begin
            n_fail++;
            $display("FAIL cd_step1: got %h expected %h", {bus.state, bus.count_val}, {3'd2, 4'd1});
        end
        step(3);
        n_checks++;
        if ({bus.state, bus.count_val} !== {3'd2, 4'd1}) begin
            n_fail++;
            $display("FAIL cd_hold1: got %h expected %h", {bus.state, bus.count_val}, {3'd2, 4'd1});
        end
        step(1);
        n_checks++;
        if ({bus.state, bus.count_val, bus.round_rst} !== {3'd4, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL cd_to_race: got %h expected %h", {bus.state, bus.count_val, bus.round_rst}, {3'd4, 4'd0, 1'b0});
        end
        step(7);
        n_checks++;
        if ({bus.state, bus.round_rst, bus.race_secs} !== {3'd4, 1'b0, 10'd1}) begin
            n_fail++;
            $display("FAIL cd_no_restart: got %h expected %h", {bus.state, bus.round_rst, bus.race_secs}, {3'd4, 1'b0, 10'd1});
        end
        bus.start_key = 1'b0;
    endtask

    task automatic test_lap;
        step(1);
        bus.start_key = 1'b1;
        step(1);
        n_checks++;
        if ({bus.state, bus.round_rst} !== {3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL race_start_ignored: got %h expected %h", {bus.state, bus.round_rst}, {3'd4, 1'b0});
        end
        bus.start_key = 1'b0;
        set_pos(10'd300, 10'd116, 10'd150, 10'd200);
        step(1);
        set_pos(10'd20, 10'd116, 10'd150, 10'd200);
        step(1);
        n_checks++;
        if (bus.p1_lap !== 3'd1) begin
            n_fail++;
            $display("FAIL lap_first: got %0d expected %0d", bus.p1_lap, 1);
        end
        step(4);
        n_checks++;
        if ({bus.state, bus.p1_lap} !== {3'd4, 3'd1}) begin
            n_fail++;
            $display("FAIL lap_once: got %h expected %h", {bus.state, bus.p1_lap}, {3'd4, 3'd1});
        end
        set_pos(10'd150, 10'd200, 10'd150, 10'd200);
        step(2);
        set_pos(10'd20, 10'd116, 10'd150, 10'd200);
        step(3);
        n_checks++;
        if ({bus.p1_lap, bus.p2_lap} !== {3'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL lap_unarmed: got %h expected %h", {bus.p1_lap, bus.p2_lap}, {3'd1, 3'd0});
        end
        set_pos(10'd150, 10'd200, 10'd150, 10'd200);
    endtask

    task automatic test_tie;
        set_pos(10'd150, 10'd200, 10'd319, 10'd118);
        step(1);
        set_pos(10'd150, 10'd200, 10'd0, 10'd115);
        step(1);
        n_checks++;
        if ({bus.state, bus.p1_lap, bus.p2_lap} !== {3'd4, 3'd1, 3'd1}) begin
            n_fail++;
            $display("FAIL tie_p2_lap1: got %h expected %h", {bus.state, bus.p1_lap, bus.p2_lap}, {3'd4, 3'd1, 3'd1});
        end
        set_pos(10'd150, 10'd200, 10'd150, 10'd200);
        step(1);
        set_pos(10'd280, 10'd115, 10'd300, 10'd117);
        step(1);
        set_pos(10'd40, 10'd118, 10'd5, 10'd116);
        step(1);
        n_checks++;
        if ({bus.state, bus.winner, bus.p1_lap, bus.p2_lap} !== {3'd5, 2'd3, 3'd2, 3'd2}) begin
            n_fail++;
            $display("FAIL tie_finish: got %h expected %h", {bus.state, bus.winner, bus.p1_lap, bus.p2_lap}, {3'd5, 2'd3, 3'd2, 3'd2});
        end
        set_pos(10'd150, 10'd200, 10'd150, 10'd200);
    endtask

    task automatic test_finish_hold;
        step(3);
        n_checks++;
        if ({bus.state, bus.winner, bus.p1_lap, bus.p2_lap} !== {3'd5, 2'd3, 3'd2, 3'd2}) begin
            n_fail++;
            $display("FAIL finish_hold: got %h expected %h", {bus.state, bus.winner, bus.p1_lap, bus.p2_lap}, {3'd5, 2'd3, 3'd2, 3'd2});
        end
        bus.start_key = 1'b1;
        step(1);
        n_checks++;
        if ({bus.state, bus.winner, bus.p1_lap, bus.p2_lap, bus.round_rst} !== {3'd0, 2'd3, 3'd2, 3'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL finish_to_idle: got %h expected %h", {bus.state, bus.winner, bus.p1_lap, bus.p2_lap, bus.round_rst}, {3'd0, 2'd3, 3'd2, 3'd2, 1'b0});
        end
        bus.start_key = 1'b0;
        step(1);
    endtask

    task automatic test_p2_win;
        // P1 parks in the checkpoint during countdown; that must not arm it
        set_pos(10'd300, 10'd116, 10'd150, 10'd200);
        bus.start_key = 1'b1;
        step(1);
        n_checks++;
        if ({bus.state, bus.count_val, bus.round_rst, bus.p1_lap, bus.p2_lap, bus.winner, bus.race_secs} !==
            {3'd2, 4'd3, 1'b1, 3'd0, 3'd0, 2'd0, 10'd0}) begin
            n_fail++;
            $display("FAIL restart_clear: got %h expected %h",
                     {bus.state, bus.count_val, bus.round_rst, bus.p1_lap, bus.p2_lap, bus.winner, bus.race_secs},
                     {3'd2, 4'd3, 1'b1, 3'd0, 3'd0, 2'd0, 10'd0});
        end
        bus.start_key = 1'b0;
        step(12);
        set_pos(10'd20, 10'd116, 10'd300, 10'd116);
        step(1);
        set_pos(10'd20, 10'd116, 10'd20, 10'd116);
        step(1);
        n_checks++;
        if ({bus.state, bus.p1_lap, bus.p2_lap} !== {3'd4, 3'd0, 3'd1}) begin
            n_fail++;
            $display("FAIL p2_lap1: got %h expected %h", {bus.state, bus.p1_lap, bus.p2_lap}, {3'd4, 3'd0, 3'd1});
        end
        set_pos(10'd20, 10'd116, 10'd150, 10'd200);
        step(7);
        n_checks++;
        if (bus.race_secs !== 10'd2) begin
            n_fail++;
            $display("FAIL race_secs_count: got %0d expected %0d", bus.race_secs, 2);
        end
        set_pos(10'd20, 10'd116, 10'd300, 10'd116);
        step(1);
        set_pos(10'd20, 10'd116, 10'd20, 10'd116);
        step(1);
        n_checks++;
        if ({bus.state, bus.winner, bus.p1_lap, bus.p2_lap, bus.race_secs} !== {3'd5, 2'd2, 3'd0, 3'd2, 10'd2}) begin
            n_fail++;
            $display("FAIL p2_win: got %h expected %h", {bus.state, bus.winner, bus.p1_lap, bus.p2_lap, bus.race_secs},
                     {3'd5, 2'd2, 3'd0, 3'd2, 10'd2});
        end
        set_pos(10'd300, 10'd116, 10'd150, 10'd200);
        step(3);
        set_pos(10'd20, 10'd116, 10'd150, 10'd200);
        step(3);
        n_checks++;
        if ({bus.state, bus.winner, bus.p1_lap, bus.p2_lap, bus.race_secs} !== {3'd5, 2'd2, 3'd0, 3'd2, 10'd2}) begin
            n_fail++;
            $display("FAIL p2_win_frozen: got %h expected %h", {bus.state, bus.winner, bus.p1_lap, bus.p2_lap, bus.race_secs},
                     {3'd5, 2'd2, 3'd0, 3'd2, 10'd2});
        end
        set_pos(10'd150, 10'd200, 10'd150, 10'd200);
        bus.start_key = 1'b1;
        step(1);
        n_checks++;
        if ({bus.state, bus.race_secs} !== {3'd0, 10'd2}) begin
            n_fail++;
            $display("FAIL p2_win_to_idle: got %h expected %h", {bus.state, bus.race_secs}, {3'd0, 10'd2});
        end
        bus.start_key = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_race;
        logic [25:0] got;
        bus.start_key = 1'b1;
        step(1);
        bus.start_key = 1'b0;
        step(12);
        set_pos(10'd300, 10'd116, 10'd150, 10'd200);
        step(1);
        set_pos(10'd20, 10'd116, 10'd150, 10'd200);
        step(1);
        n_checks++;
        if ({bus.state, bus.p1_lap} !== {3'd4, 3'd1}) begin
            n_fail++;
            $display("FAIL midrace_lap: got %h expected %h", {bus.state, bus.p1_lap}, {3'd4, 3'd1});
        end
        set_pos(10'd150, 10'd200, 10'd150, 10'd200);
        rst = 1'b1;
        bus.start_key = 1'b1;
        step(1);
        got = {bus.state, bus.count_val, bus.round_rst, bus.p1_lap, bus.p2_lap, bus.winner, bus.race_secs};
        n_checks++;
        if (got !== 26'd0) begin
            n_fail++;
            $display("FAIL midrace_reset: got %h expected %h", got, 26'd0);
        end
        step(1);
        rst = 1'b0;
        step(1);
        n_checks++;
        if ({bus.state, bus.count_val, bus.round_rst} !== {3'd2, 4'd3, 1'b1}) begin
            n_fail++;
            $display("FAIL post_reset_start: got %h expected %h", {bus.state, bus.count_val, bus.round_rst}, {3'd2, 4'd3, 1'b1});
        end
        bus.start_key = 1'b0;
        step(3);
        n_checks++;
        if ({bus.state, bus.count_val, bus.round_rst} !== {3'd2, 4'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL post_reset_cd3: got %h expected %h", {bus.state, bus.count_val, bus.round_rst}, {3'd2, 4'd3, 1'b0});
        end
        step(1);
        n_checks++;
        if ({bus.state, bus.count_val} !== {3'd2, 4'd2}) begin
            n_fail++;
            $display("FAIL post_reset_cd2: got %h expected %h", {bus.state, bus.count_val}, {3'd2, 4'd2});
        end
    endtask

    task automatic test_saturation;
        rst2 = 1'b0;
        bus2.start_key = 1'b1;
        step(1);
        n_checks++;
        if ({bus2.state, bus2.count_val} !== {3'd2, 4'd1}) begin
            n_fail++;
            $display("FAIL sat_cd: got %h expected %h", {bus2.state, bus2.count_val}, {3'd2, 4'd1});
        end
        step(1);
        n_checks++;
        if ({bus2.state, bus2.race_secs} !== {3'd4, 10'd0}) begin
            n_fail++;
            $display("FAIL sat_race: got %h expected %h", {bus2.state, bus2.race_secs}, {3'd4, 10'd0});
        end
        step(998);
        n_checks++;
        if (bus2.race_secs !== 10'd998) begin
            n_fail++;
            $display("FAIL sat_998: got %0d expected %0d", bus2.race_secs, 998);
        end
        step(1);
        n_checks++;
        if (bus2.race_secs !== 10'd999) begin
            n_fail++;
            $display("FAIL sat_999: got %0d expected %0d", bus2.race_secs, 999);
        end
        step(5);
        n_checks++;
        if ({bus2.state, bus2.race_secs} !== {3'd4, 10'd999}) begin
            n_fail++;
            $display("FAIL sat_hold: got %h expected %h", {bus2.state, bus2.race_secs}, {3'd4, 10'd999});
        end
        bus2.start_key = 1'b0;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_lap();
        test_tie();
        test_finish_hold();
        test_p2_win();
        test_reset_mid_race();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
